inst_fetch_unit: RTL and testbench

Instruction fetch stage that feeds the 5-bit `inst` bus consumed by the control unit. It owns the program counter and issues instruction-memory addresses. It captures each instruction word and holds it stable for the execute half of the two-phase FETCH/EXEC pipeline. It applies PC loads (jumps/branches) and halt requests returned from the decoded control signals.

---
 rtl/turtle_pkg.sv | 19 +
 rtl/inst_fetch_unit.sv | 89 ++++++++
 tb/tb_inst_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/turtle_pkg.sv
// rtl/turtle_pkg.sv - shared constants and types for the turtle fetch/control pipeline
// Purpose: phase constants shared with the control unit, fetch FSM state
//          encoding and the default instruction width.
// Ports:   none (package).
package turtle_pkg;

  // Phase values seen on the phase output; the control unit uses the same constants.
  localparam logic PHASE_FETCH = 1'b0;
  localparam logic PHASE_EXEC  = 1'b1;

  localparam int DEFAULT_INST_W = 5;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - two-phase instruction fetch stage with PC, IR and retire counter
// Purpose: owns the program counter, drives the instruction-memory address,
//          captures the instruction word in FETCH and holds it through EXEC,
//          applies jumps and halts returned by the control unit.
// Ports:   clk, reset (async, active high), stall
//          pc_load / pc_load_addr / halt : control feedback, sampled in EXEC only
//          imem_addr (out, = pc), imem_data (in, combinational read)
//          inst, phase, pc, halted, retired : stage outputs
module inst_fetch_unit
  import turtle_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = DEFAULT_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic              phase,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [15:0]       retired_q, retired_d;
  logic              phase_q, phase_d;
  logic              halted_q, halted_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    // HALT is terminal: nothing but reset can move it, stall included.
    if (!stall) begin
      unique case (state_q)
        ST_FETCH: begin
          inst_d  = imem_data;
          pc_d    = pc_q + 1'b1;  // natural wrap at 2^ADDR_W
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          // A jump still lands on the halting edge so pc shows the target.
          if (pc_load) pc_d = pc_load_addr;
          if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
          state_d = halt ? ST_HALT : ST_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
    phase_d  = (state_d == ST_FETCH) ? PHASE_FETCH : PHASE_EXEC;
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      phase_q   <= PHASE_FETCH;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      phase_q   <= phase_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign retired   = retired_q;
  assign phase     = phase_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset_w = 1'b1;
  logic       stall = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_addr = 8'h00;
  logic       halt = 1'b0;
  logic [7:0] imem_addr, pc, imem_addr_w, pc_w;
  logic [4:0] imem_data, inst, imem_data_w, inst_w;
  logic       phase, halted, phase_w, halted_w;
  logic [15:0] retired, retired_w;

  logic [4:0] imem [256];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int  m_pc, m_inst, m_ret;
  bit  m_exec, m_halted;

  assign imem_data   = imem[imem_addr];
  assign imem_data_w = imem[imem_addr_w];

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(8), .INST_W(5), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .halt(halt), .imem_addr(imem_addr),
    .imem_data(imem_data), .inst(inst), .phase(phase), .pc(pc),
    .halted(halted), .retired(retired)
  );

  inst_fetch_unit #(.ADDR_W(8), .INST_W(5), .RESET_PC(8'hFF)) dut_w (
    .clk(clk), .reset(reset_w), .stall(stall), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .halt(halt), .imem_addr(imem_addr_w),
    .imem_data(imem_data_w), .inst(inst_w), .phase(phase_w), .pc(pc_w),
    .halted(halted_w), .retired(retired_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 0; pc_load = 0; halt = 0; pc_load_addr = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
    checks++; if (phase !== 1'b0 || halted !== 1'b0 || retired !== 16'd0 || inst !== 5'd0) begin
      errors++; $display("FAIL reset_outs got ph=%b h=%b r=%0d i=%h exp 0 0 0 0", phase, halted, retired, inst); end
    // Drive to EXEC with pc = 0x17
    tick();
    pc_load = 1; pc_load_addr = 8'h16; tick();
    pc_load = 0; tick();
    checks++; if (pc !== 8'h17 || phase !== 1'b1) begin errors++; $display("FAIL reset_setup got pc=%h ph=%b exp 17 1", pc, phase); end
    #2 reset = 1;
    #1;
    checks++; if (pc !== 8'h00 || phase !== 1'b0 || retired !== 16'd0 || inst !== 5'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc=%h ph=%b r=%0d i=%h h=%b exp 00 0 0 00 0", pc, phase, retired, inst, halted); end
    tick();
    reset = 0;
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_imem_addr got %h exp 00", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [4:0] exp_i [3];
    exp_i[0] = 5'h03; exp_i[1] = 5'h1F; exp_i[2] = 5'h0A;
    imem[0] = 5'h03; imem[1] = 5'h1F; imem[2] = 5'h0A;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (inst !== exp_i[k] || pc !== 8'(k + 1) || phase !== 1'b1) begin
        errors++; $display("FAIL seq_exec%0d got i=%h pc=%h ph=%b exp %h %h 1", k, inst, pc, phase, exp_i[k], k + 1); end
      tick();
    end
    checks++; if (retired !== 16'd3 || phase !== 1'b0) begin errors++; $display("FAIL seq_retired got %0d ph=%b exp 3 0", retired, phase); end
  endtask

  task automatic test_jump();
    do_reset();
    tick();
    pc_load = 1; pc_load_addr = 8'h40; tick();
    pc_load = 0;
    checks++; if (imem_addr !== 8'h40 || phase !== 1'b0) begin errors++; $display("FAIL jump_addr got %h ph=%b exp 40 0", imem_addr, phase); end
    pc_load = 1; pc_load_addr = 8'h05; tick();
    pc_load = 0;
    checks++; if (pc !== 8'h41 || phase !== 1'b1) begin errors++; $display("FAIL jump_in_fetch got %h exp 41", pc); end
  endtask

  task automatic test_wrap();
    reset_w = 1; #1;
    checks++; if (pc_w !== 8'hFF) begin errors++; $display("FAIL wrap_reset_pc got %h exp ff", pc_w); end
    tick(); reset_w = 0;
    tick();
    checks++; if (pc_w !== 8'h00 || phase_w !== 1'b1) begin errors++; $display("FAIL wrap_pc got %h exp 00", pc_w); end
    tick();
    checks++; if (imem_addr_w !== 8'h00 || phase_w !== 1'b0) begin errors++; $display("FAIL wrap_next_fetch got %h exp 00", imem_addr_w); end
    reset_w = 1;
  endtask

  task automatic test_stall();
    imem[0] = 5'h0A;
    do_reset();
    tick();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (inst !== 5'h0A || pc !== 8'h01 || phase !== 1'b1 || retired !== 16'd0) begin
        errors++; $display("FAIL stall%0d got i=%h pc=%h ph=%b r=%0d exp 0a 01 1 0", k, inst, pc, phase, retired); end
    end
    stall = 0; tick();
    checks++; if (phase !== 1'b0 || retired !== 16'd1) begin errors++; $display("FAIL stall_resume got ph=%b r=%0d exp 0 1", phase, retired); end
  endtask

  task automatic test_halt_jump();
    logic [4:0] held_i;
    do_reset();
    tick();
    held_i = imem[0];
    halt = 1; pc_load = 1; pc_load_addr = 8'h10; tick();
    halt = 0; pc_load = 0;
    checks++; if (halted !== 1'b1 || pc !== 8'h10 || retired !== 16'd1 || phase !== 1'b1) begin
      errors++; $display("FAIL halt_jump got h=%b pc=%h r=%0d ph=%b exp 1 10 1 1", halted, pc, retired, phase); end
    for (int k = 0; k < 4; k++) begin
      stall = k[0]; pc_load = 1; pc_load_addr = 8'h33; halt = k[1];
      tick();
      checks++; if (halted !== 1'b1 || pc !== 8'h10 || retired !== 16'd1 || inst !== held_i) begin
        errors++; $display("FAIL halt_hold%0d got h=%b pc=%h r=%0d i=%h exp 1 10 1 %h", k, halted, pc, retired, inst, held_i); end
    end
    stall = 0; pc_load = 0; halt = 0;
    #2 reset = 1; #1;
    checks++; if (halted !== 1'b0 || phase !== 1'b0 || pc !== 8'h00) begin
      errors++; $display("FAIL halt_recover got h=%b ph=%b pc=%h exp 0 0 00", halted, phase, pc); end
    tick(); reset = 0;
  endtask

  task automatic test_random();
    bit s, pl, h;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) imem[i] = 5'($urandom);
    do_reset();
    m_pc = 0; m_inst = 0; m_ret = 0; m_exec = 0; m_halted = 0;
    for (int n = 0; n < 600; n++) begin
      if (m_halted && ($urandom % 4 == 0)) begin
        do_reset();
        m_pc = 0; m_inst = 0; m_ret = 0; m_exec = 0; m_halted = 0;
      end
      s  = ($urandom % 4) == 0;
      pl = ($urandom % 3) == 0;
      h  = ($urandom % 16) == 0;
      a  = 8'($urandom);
      stall = s; pc_load = pl; pc_load_addr = a; halt = h;
      if (!s && !m_halted) begin
        if (!m_exec) begin
          m_inst = int'(imem[m_pc]);
          m_pc   = (m_pc + 1) % 256;
          m_exec = 1;
        end else begin
          if (pl) m_pc = int'(a);
          if (m_ret < 65535) m_ret++;
          if (h) m_halted = 1;
          m_exec = 0;
        end
      end
      tick();
      checks++;
      if (pc !== 8'(m_pc) || imem_addr !== 8'(m_pc) || inst !== 5'(m_inst) || retired !== 16'(m_ret) ||
          phase !== (m_exec | m_halted) || halted !== m_halted) begin
        errors++;
        $display("FAIL rand%0d got pc=%h i=%h r=%0d ph=%b h=%b exp %h %h %0d %b %b",
                 n, pc, inst, retired, phase, halted, m_pc[7:0], m_inst[4:0], m_ret, m_exec | m_halted, m_halted);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 5'(i);
    #1;
    test_reset();
    test_sequential();
    test_jump();
    test_wrap();
    test_stall();
    test_halt_jump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
